sram_frame_arbiter: RTL and testbench

//   Per-cycle arbiter/sequencer for the single-port async 16-bit frame SRAM. Shares it between the
//   VGA scan-out fetch (address {X,Y}), one client port (e.g. walker: neighbour reads, pixel writes)
//   and an internal frame-clear engine. Owns all SRAM control pins and DQ drive; sits between
//   VGA_Controller coordinates/colour inputs and the SRAM pads.

---
 rtl/sram_frame_arbiter_if.sv | 59 +++++
 rtl/sram_frame_arbiter.sv | 213 +++++++++++++++++++++
 tb/tb_sram_frame_arbiter.sv | 407 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sram_frame_arbiter_if.sv
// Bundle of every arbiter signal except clock and reset: display fetch, client port,
// clear control and the SRAM pad side. The arbiter takes the slave view; whatever surrounds it
// (VGA controller, walker, pad ring or a bench) takes the master view.
interface sram_frame_arbiter_if #(
    parameter int unsigned X_W    = 10,
    parameter int unsigned Y_W    = 10,
    parameter int unsigned DATA_W = 16
);
    // Display fetch
    logic                 iVGA_REQ;
    logic [X_W-1:0]       iCoord_X;
    logic [Y_W-1:0]       iCoord_Y;
    logic [DATA_W-1:0]    oPIX_DATA;
    logic                 oPIX_MISS;

    // Client port
    logic                 iCL_REQ;
    logic                 iCL_WE;
    logic [X_W-1:0]       iCL_X;
    logic [Y_W-1:0]       iCL_Y;
    logic [DATA_W-1:0]    iCL_WDATA;
    logic                 oCL_ACK;
    logic [DATA_W-1:0]    oCL_RDATA;

    // Frame clear
    logic                 iCLR_START;
    logic [DATA_W-1:0]    iCLR_DATA;
    logic                 oCLR_BUSY;

    // SRAM pads
    logic [X_W+Y_W-1:0]   oSRAM_ADDR;
    logic                 oSRAM_WE_N;
    logic                 oSRAM_OE_N;
    logic                 oSRAM_DQ_OE;
    logic [DATA_W-1:0]    oSRAM_DQ;
    logic [DATA_W-1:0]    iSRAM_DQ;

    modport slave (
        input  iVGA_REQ, iCoord_X, iCoord_Y,
        output oPIX_DATA, oPIX_MISS,
        input  iCL_REQ, iCL_WE, iCL_X, iCL_Y, iCL_WDATA,
        output oCL_ACK, oCL_RDATA,
        input  iCLR_START, iCLR_DATA,
        output oCLR_BUSY,
        output oSRAM_ADDR, oSRAM_WE_N, oSRAM_OE_N, oSRAM_DQ_OE, oSRAM_DQ,
        input  iSRAM_DQ
    );

    modport master (
        output iVGA_REQ, iCoord_X, iCoord_Y,
        input  oPIX_DATA, oPIX_MISS,
        output iCL_REQ, iCL_WE, iCL_X, iCL_Y, iCL_WDATA,
        input  oCL_ACK, oCL_RDATA,
        output iCLR_START, iCLR_DATA,
        input  oCLR_BUSY,
        input  oSRAM_ADDR, oSRAM_WE_N, oSRAM_OE_N, oSRAM_DQ_OE, oSRAM_DQ,
        output iSRAM_DQ
    );
endinterface

// File: rtl/sram_frame_arbiter.sv
// Per-cycle arbiter/sequencer for the single-port async frame SRAM. Shares the SRAM between the
// display scan-out fetch, one client port and a frame-clear engine. All SRAM control pins are
// registered here; every write is followed by a turnaround cycle before the bus is reused.
//
// Client handshake: the request is held until the ACK cycle. During the ACK cycle the client must
// either drop the request or already present its next one; only an operation still in flight
// (issued on the previous edge) blocks a regrant.
module sram_frame_arbiter #(
    parameter int unsigned X_W        = 10,
    parameter int unsigned Y_W        = 10,
    parameter int unsigned DATA_W     = 16,
    parameter int unsigned H_MAX      = 639,
    parameter int unsigned V_MAX      = 479,
    parameter int unsigned STARVE_MAX = 1023
) (
    input  logic                iCLK,
    input  logic                iRST_N,
    sram_frame_arbiter_if.slave bus
);

    localparam int unsigned A_W   = X_W + Y_W;
    localparam int unsigned CNT_W = $clog2(STARVE_MAX + 1);

    // Bus state: what was issued on the most recent edge
    localparam logic [1:0] StIdle = 2'd0;
    localparam logic [1:0] StRd   = 2'd1;
    localparam logic [1:0] StWr   = 2'd2;
    localparam logic [1:0] StTurn = 2'd3;

    // Registered state
    logic [1:0]        state_q, state_d;
    logic              op_cl_q, op_cl_d;        // current RD/WR belongs to the client
    logic [A_W-1:0]    addr_q, addr_d;
    logic              we_n_q, we_n_d;
    logic              oe_n_q, oe_n_d;
    logic              dq_oe_q, dq_oe_d;
    logic [DATA_W-1:0] dq_q, dq_d;
    logic [DATA_W-1:0] pix_data_q, pix_data_d;
    logic              pix_miss_q, pix_miss_d;
    logic [DATA_W-1:0] cl_rdata_q, cl_rdata_d;
    logic              cl_ack_q, cl_ack_d;
    logic [CNT_W-1:0]  starve_q, starve_d;
    logic              clr_busy_q, clr_busy_d;
    logic [X_W-1:0]    clr_x_q, clr_x_d;
    logic [Y_W-1:0]    clr_y_q, clr_y_d;
    logic [DATA_W-1:0] clr_data_q, clr_data_d;

    // Grant decision for the coming edge
    logic cl_inflight;
    logic cl_want;
    logic starve_hit;
    logic g_turn, g_cl, g_vga, g_clr;

    // Fixed-priority grant: turnaround, starved client, display, client, clear
    always_comb begin
        cl_inflight = ((state_q == StRd) || (state_q == StWr)) && op_cl_q;
        cl_want     = bus.iCL_REQ && !cl_inflight;
        starve_hit  = cl_want && (starve_q == CNT_W'(STARVE_MAX));
        g_turn      = 1'b0;
        g_cl        = 1'b0;
        g_vga       = 1'b0;
        g_clr       = 1'b0;
        if (state_q == StWr) begin
            g_turn = 1'b1;
        end else if (starve_hit) begin
            g_cl = 1'b1;
        end else if (bus.iVGA_REQ) begin
            g_vga = 1'b1;
        end else if (cl_want) begin
            g_cl = 1'b1;
        end else if (clr_busy_q && !bus.iCLR_START) begin
            // A restart in this cycle would make the old scan position stale
            g_clr = 1'b1;
        end
    end

    // SRAM command for the coming edge; pins idle (deasserted) unless a read or write is issued
    always_comb begin
        state_d = StIdle;
        op_cl_d = op_cl_q;
        addr_d  = addr_q;
        dq_d    = dq_q;
        we_n_d  = 1'b1;
        oe_n_d  = 1'b1;
        dq_oe_d = 1'b0;
        if (g_turn) begin
            state_d = StTurn;
        end else if (g_vga) begin
            state_d = StRd;
            op_cl_d = 1'b0;
            addr_d  = {bus.iCoord_X, bus.iCoord_Y};
            oe_n_d  = 1'b0;
        end else if (g_cl) begin
            op_cl_d = 1'b1;
            addr_d  = {bus.iCL_X, bus.iCL_Y};
            if (bus.iCL_WE) begin
                state_d = StWr;
                dq_d    = bus.iCL_WDATA;
                dq_oe_d = 1'b1;
                we_n_d  = 1'b0;
            end else begin
                state_d = StRd;
                oe_n_d  = 1'b0;
            end
        end else if (g_clr) begin
            state_d = StWr;
            op_cl_d = 1'b0;
            addr_d  = {clr_x_q, clr_y_q};
            dq_d    = clr_data_q;
            dq_oe_d = 1'b1;
            we_n_d  = 1'b0;
        end
    end

    // Read-data capture, completion/miss pulses and starvation counter
    always_comb begin
        pix_data_d = pix_data_q;
        cl_rdata_d = cl_rdata_q;
        if (state_q == StRd) begin
            if (op_cl_q) begin
                cl_rdata_d = bus.iSRAM_DQ;
            end else begin
                pix_data_d = bus.iSRAM_DQ;
            end
        end
        cl_ack_d   = cl_inflight;
        pix_miss_d = bus.iVGA_REQ && !g_vga;

        starve_d = starve_q;
        if (g_cl) begin
            starve_d = '0;
        end else if (cl_want && (starve_q != CNT_W'(STARVE_MAX))) begin
            starve_d = starve_q + CNT_W'(1);
        end
    end

    // Clear engine: Y scans fastest, BUSY drops on the edge that issues the last pixel
    always_comb begin
        clr_busy_d = clr_busy_q;
        clr_x_d    = clr_x_q;
        clr_y_d    = clr_y_q;
        clr_data_d = clr_data_q;
        if (bus.iCLR_START) begin
            clr_busy_d = 1'b1;
            clr_x_d    = '0;
            clr_y_d    = '0;
            clr_data_d = bus.iCLR_DATA;
        end else if (g_clr) begin
            if (clr_y_q == Y_W'(V_MAX)) begin
                clr_y_d = '0;
                if (clr_x_q == X_W'(H_MAX)) begin
                    clr_x_d    = '0;
                    clr_busy_d = 1'b0;
                end else begin
                    clr_x_d = clr_x_q + X_W'(1);
                end
            end else begin
                clr_y_d = clr_y_q + Y_W'(1);
            end
        end
    end

    // State and pin registers; reset parks the bus and aborts any grant or clear
    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            state_q    <= StIdle;
            op_cl_q    <= 1'b0;
            addr_q     <= '0;
            we_n_q     <= 1'b1;
            oe_n_q     <= 1'b1;
            dq_oe_q    <= 1'b0;
            dq_q       <= '0;
            pix_data_q <= '0;
            pix_miss_q <= 1'b0;
            cl_rdata_q <= '0;
            cl_ack_q   <= 1'b0;
            starve_q   <= '0;
            clr_busy_q <= 1'b0;
            clr_x_q    <= '0;
            clr_y_q    <= '0;
            clr_data_q <= '0;
        end else begin
            state_q    <= state_d;
            op_cl_q    <= op_cl_d;
            addr_q     <= addr_d;
            we_n_q     <= we_n_d;
            oe_n_q     <= oe_n_d;
            dq_oe_q    <= dq_oe_d;
            dq_q       <= dq_d;
            pix_data_q <= pix_data_d;
            pix_miss_q <= pix_miss_d;
            cl_rdata_q <= cl_rdata_d;
            cl_ack_q   <= cl_ack_d;
            starve_q   <= starve_d;
            clr_busy_q <= clr_busy_d;
            clr_x_q    <= clr_x_d;
            clr_y_q    <= clr_y_d;
            clr_data_q <= clr_data_d;
        end
    end

    assign bus.oSRAM_ADDR  = addr_q;
    assign bus.oSRAM_WE_N  = we_n_q;
    assign bus.oSRAM_OE_N  = oe_n_q;
    assign bus.oSRAM_DQ_OE = dq_oe_q;
    assign bus.oSRAM_DQ    = dq_q;
    assign bus.oPIX_DATA   = pix_data_q;
    assign bus.oPIX_MISS   = pix_miss_q;
    assign bus.oCL_RDATA   = cl_rdata_q;
    assign bus.oCL_ACK     = cl_ack_q;
    assign bus.oCLR_BUSY   = clr_busy_q;

endmodule

// File: tb/tb_sram_frame_arbiter.sv
// Self-checking bench for sram_frame_arbiter with a behavioural async SRAM model.
// The clear region is shrunk so a full clear fits in a short run.
module tb_sram_frame_arbiter;

    localparam int X_W        = 10;
    localparam int Y_W        = 10;
    localparam int DATA_W     = 16;
    localparam int H_MAX      = 39;
    localparam int V_MAX      = 29;
    localparam int STARVE_MAX = 1023;

    logic iCLK   = 1'b0;
    logic iRST_N = 1'b1;

    always #5 iCLK = ~iCLK;

    sram_frame_arbiter_if #(.X_W(X_W), .Y_W(Y_W), .DATA_W(DATA_W)) bus ();

    sram_frame_arbiter #(
        .X_W       (X_W),
        .Y_W       (Y_W),
        .DATA_W    (DATA_W),
        .H_MAX     (H_MAX),
        .V_MAX     (V_MAX),
        .STARVE_MAX(STARVE_MAX)
    ) dut (
        .iCLK  (iCLK),
        .iRST_N(iRST_N),
        .bus   (bus)
    );

    // Async SRAM model: write committed at the end of a WE_N-low cycle, read is combinational
    logic [DATA_W-1:0] mem [0:(1<<(X_W+Y_W))-1];

    always @(posedge iCLK) begin
        if (iRST_N && !bus.oSRAM_WE_N && bus.oSRAM_DQ_OE) mem[bus.oSRAM_ADDR] <= bus.oSRAM_DQ;
    end

    assign bus.iSRAM_DQ = !bus.oSRAM_OE_N ? mem[bus.oSRAM_ADDR] : 16'hDEAD;

    int passed = 0;
    int total  = 0;
    logic [DATA_W-1:0] exp_q [$];
    logic [DATA_W-1:0] exp_mem [int];

    function automatic int pa(input int x, input int y);
        return (x << Y_W) | y;
    endfunction

    task automatic idle_inputs();
        bus.iVGA_REQ   = 1'b0;
        bus.iCoord_X   = '0;
        bus.iCoord_Y   = '0;
        bus.iCL_REQ    = 1'b0;
        bus.iCL_WE     = 1'b0;
        bus.iCL_X      = '0;
        bus.iCL_Y      = '0;
        bus.iCL_WDATA  = '0;
        bus.iCLR_START = 1'b0;
        bus.iCLR_DATA  = '0;
    endtask

    // Drive one client request; the expected result goes on the scoreboard queue
    task automatic drive_client(input logic we, input int x, input int y, input logic [15:0] wd);
        bus.iCL_REQ   = 1'b1;
        bus.iCL_WE    = we;
        bus.iCL_X     = X_W'(x);
        bus.iCL_Y     = Y_W'(y);
        bus.iCL_WDATA = wd;
        if (we) begin
            exp_mem[pa(x, y)] = wd;
            exp_q.push_back(wd);
        end else begin
            exp_q.push_back(exp_mem.exists(pa(x, y)) ? exp_mem[pa(x, y)] : 16'h0000);
        end
    endtask

    task automatic test_reset();
        logic [DATA_W-1:0] e;
        idle_inputs();
        #2 iRST_N = 1'b0;
        #1;
        total++;
        if ({bus.oSRAM_WE_N, bus.oSRAM_OE_N, bus.oSRAM_DQ_OE} !== 3'b110)
            $display("FAIL reset_ctl: we_n/oe_n/dq_oe=%b required 110",
                     {bus.oSRAM_WE_N, bus.oSRAM_OE_N, bus.oSRAM_DQ_OE});
        else passed++;
        total++;
        if (bus.oSRAM_ADDR !== 20'h0 || bus.oSRAM_DQ !== 16'h0)
            $display("FAIL reset_bus: addr=%h dq=%h required 0/0", bus.oSRAM_ADDR, bus.oSRAM_DQ);
        else passed++;
        e = 16'h0;
        total++;
        if (bus.oPIX_DATA !== e || bus.oCL_RDATA !== e)
            $display("FAIL reset_data: pix=%h rdata=%h required 0/0", bus.oPIX_DATA, bus.oCL_RDATA);
        else passed++;
        total++;
        if ({bus.oCL_ACK, bus.oPIX_MISS, bus.oCLR_BUSY} !== 3'b000)
            $display("FAIL reset_flags: ack/miss/busy=%b required 000",
                     {bus.oCL_ACK, bus.oPIX_MISS, bus.oCLR_BUSY});
        else passed++;
        repeat (2) @(negedge iCLK);
        iRST_N = 1'b1;
        @(negedge iCLK);
    endtask

    task automatic test_vga_read();
        mem[pa(5, 7)] = 16'hABCD;
        bus.iVGA_REQ = 1'b1;
        bus.iCoord_X = 10'd5;
        bus.iCoord_Y = 10'd7;
        @(negedge iCLK);
        total++;
        if (bus.oSRAM_ADDR !== 20'h01407 || bus.oSRAM_OE_N !== 1'b0)
            $display("FAIL vga_issue: addr=%h oe_n=%b required 01407/0",
                     bus.oSRAM_ADDR, bus.oSRAM_OE_N);
        else passed++;
        @(negedge iCLK);
        total++;
        if (bus.oPIX_DATA !== 16'hABCD)
            $display("FAIL vga_data: pix=%h required abcd", bus.oPIX_DATA);
        else passed++;
        total++;
        if (bus.oPIX_MISS !== 1'b0) $display("FAIL vga_nomiss: miss=%b required 0", bus.oPIX_MISS);
        else passed++;
        bus.iVGA_REQ = 1'b0;
        @(negedge iCLK);
    endtask

    task automatic test_write_read();
        logic [DATA_W-1:0] e;
        drive_client(1'b1, 3, 4, 16'h1234);
        @(negedge iCLK);
        total++;
        if ({bus.oSRAM_WE_N, bus.oSRAM_OE_N, bus.oSRAM_DQ_OE} !== 3'b011 ||
            bus.oSRAM_ADDR !== 20'h00C04 || bus.oSRAM_DQ !== 16'h1234)
            $display("FAIL wr_issue: we/oe/dqoe=%b addr=%h dq=%h required 011/00c04/1234",
                     {bus.oSRAM_WE_N, bus.oSRAM_OE_N, bus.oSRAM_DQ_OE}, bus.oSRAM_ADDR,
                     bus.oSRAM_DQ);
        else passed++;
        @(negedge iCLK);
        total++;
        if (bus.oCL_ACK !== 1'b1 ||
            {bus.oSRAM_WE_N, bus.oSRAM_OE_N, bus.oSRAM_DQ_OE} !== 3'b110)
            $display("FAIL wr_turn: ack=%b we/oe/dqoe=%b required 1/110", bus.oCL_ACK,
                     {bus.oSRAM_WE_N, bus.oSRAM_OE_N, bus.oSRAM_DQ_OE});
        else passed++;
        e = exp_q.pop_front();
        total++;
        if (mem[pa(3, 4)] !== e) $display("FAIL wr_mem: sram=%h required %h", mem[pa(3, 4)], e);
        else passed++;
        // Next request presented in the ACK cycle: read issues straight after the turnaround
        drive_client(1'b0, 3, 4, 16'h0000);
        @(negedge iCLK);
        total++;
        if (bus.oSRAM_OE_N !== 1'b0 || bus.oSRAM_ADDR !== 20'h00C04 || bus.oCL_ACK !== 1'b0)
            $display("FAIL rd_issue: oe_n=%b addr=%h ack=%b required 0/00c04/0",
                     bus.oSRAM_OE_N, bus.oSRAM_ADDR, bus.oCL_ACK);
        else passed++;
        @(negedge iCLK);
        e = exp_q.pop_front();
        total++;
        if (bus.oCL_ACK !== 1'b1 || bus.oCL_RDATA !== e)
            $display("FAIL rd_data: ack=%b rdata=%h required 1/%h", bus.oCL_ACK, bus.oCL_RDATA, e);
        else passed++;
        bus.iCL_REQ = 1'b0;
        @(negedge iCLK);
        total++;
        if (bus.oCL_ACK !== 1'b0) $display("FAIL ack_pulse: ack=%b required 0", bus.oCL_ACK);
        else passed++;
    endtask

    task automatic test_starve();
        int grant_edge = 0;
        int ack_edge   = 0;
        int misses     = 0;
        logic [DATA_W-1:0] e;
        bus.iVGA_REQ = 1'b1;
        bus.iCoord_X = 10'd5;
        bus.iCoord_Y = 10'd7;
        drive_client(1'b0, 3, 4, 16'h0000);
        for (int n = 1; n <= 1100 && (ack_edge == 0 || n <= ack_edge + 6); n++) begin
            @(negedge iCLK);
            if (bus.oPIX_MISS) misses++;
            if (grant_edge == 0 && !bus.oSRAM_OE_N && bus.oSRAM_ADDR == 20'h00C04) grant_edge = n;
            if (bus.oCL_ACK) begin
                ack_edge = n;
                bus.iCL_REQ = 1'b0;
                e = exp_q.pop_front();
                total++;
                if (bus.oCL_RDATA !== e)
                    $display("FAIL starve_rdata: rdata=%h required %h", bus.oCL_RDATA, e);
                else passed++;
            end
        end
        total++;
        if (grant_edge != STARVE_MAX + 1)
            $display("FAIL starve_grant: granted at edge %0d required %0d", grant_edge,
                     STARVE_MAX + 1);
        else passed++;
        total++;
        if (ack_edge != STARVE_MAX + 2)
            $display("FAIL starve_ack: ack at edge %0d required %0d", ack_edge, STARVE_MAX + 2);
        else passed++;
        total++;
        if (misses != 1) $display("FAIL starve_miss: %0d misses required 1", misses);
        else passed++;
        total++;
        if (bus.oPIX_DATA !== 16'hABCD)
            $display("FAIL starve_pix: pix=%h required abcd", bus.oPIX_DATA);
        else passed++;
        bus.iVGA_REQ = 1'b0;
        @(negedge iCLK);
    endtask

    task automatic test_write_then_vga();
        logic [DATA_W-1:0] e;
        mem[pa(6, 7)] = 16'h7777;
        drive_client(1'b1, 10, 20, 16'h5555);
        @(negedge iCLK);
        total++;
        if (bus.oSRAM_WE_N !== 1'b0) $display("FAIL wv_write: we_n=%b required 0", bus.oSRAM_WE_N);
        else passed++;
        bus.iVGA_REQ = 1'b1;
        bus.iCoord_X = 10'd6;
        bus.iCoord_Y = 10'd7;
        @(negedge iCLK);
        total++;
        if (bus.oPIX_MISS !== 1'b1 || bus.oPIX_DATA !== 16'hABCD)
            $display("FAIL wv_miss: miss=%b pix=%h required 1/abcd", bus.oPIX_MISS, bus.oPIX_DATA);
        else passed++;
        total++;
        if (bus.oCL_ACK !== 1'b1 ||
            {bus.oSRAM_WE_N, bus.oSRAM_OE_N, bus.oSRAM_DQ_OE} !== 3'b110)
            $display("FAIL wv_turn: ack=%b we/oe/dqoe=%b required 1/110", bus.oCL_ACK,
                     {bus.oSRAM_WE_N, bus.oSRAM_OE_N, bus.oSRAM_DQ_OE});
        else passed++;
        e = exp_q.pop_front();
        total++;
        if (mem[pa(10, 20)] !== e)
            $display("FAIL wv_mem: sram=%h required %h", mem[pa(10, 20)], e);
        else passed++;
        bus.iCL_REQ = 1'b0;
        @(negedge iCLK);
        total++;
        if (bus.oSRAM_OE_N !== 1'b0 || bus.oSRAM_ADDR !== 20'h01807 || bus.oPIX_MISS !== 1'b0)
            $display("FAIL wv_rd: oe_n=%b addr=%h miss=%b required 0/01807/0",
                     bus.oSRAM_OE_N, bus.oSRAM_ADDR, bus.oPIX_MISS);
        else passed++;
        @(negedge iCLK);
        total++;
        if (bus.oPIX_DATA !== 16'h7777)
            $display("FAIL wv_pix: pix=%h required 7777", bus.oPIX_DATA);
        else passed++;
        bus.iVGA_REQ = 1'b0;
        @(negedge iCLK);
    endtask

    task automatic test_clear();
        logic [X_W-1:0] ex;
        logic [Y_W-1:0] ey;
        int writes = 0, bad = 0, bad_turn = 0, falls = 0, badpix = 0, tail = -1;
        logic prev_we_low, prev_busy;
        logic [DATA_W-1:0] e;
        mem[pa(H_MAX + 1, 0)] = 16'h5A5A;
        mem[pa(0, V_MAX + 1)] = 16'h3C3C;
        bus.iCLR_START = 1'b1;
        bus.iCLR_DATA  = 16'hFFFF;
        @(negedge iCLK);
        bus.iCLR_START = 1'b0;
        total++;
        if (bus.oCLR_BUSY !== 1'b1) $display("FAIL clr_busy: busy=%b required 1", bus.oCLR_BUSY);
        else passed++;
        repeat (37) @(negedge iCLK);
        // Restart mid-clear with the real fill value
        bus.iCLR_START = 1'b1;
        bus.iCLR_DATA  = 16'h0000;
        @(negedge iCLK);
        bus.iCLR_START = 1'b0;
        total++;
        if (bus.oCLR_BUSY !== 1'b1 || bus.oSRAM_WE_N !== 1'b1)
            $display("FAIL clr_restart: busy=%b we_n=%b required 1/1", bus.oCLR_BUSY,
                     bus.oSRAM_WE_N);
        else passed++;
        ex = '0;
        ey = '0;
        prev_we_low = 1'b0;
        prev_busy   = 1'b1;
        for (int c = 0; c < 4000 && tail != 0; c++) begin
            @(negedge iCLK);
            if (!bus.oSRAM_WE_N) begin
                writes++;
                if (bus.oSRAM_ADDR !== {ex, ey} || bus.oSRAM_DQ !== 16'h0000) bad++;
                if (prev_we_low) bad_turn++;
                if (int'(ey) == V_MAX) begin
                    ey = '0;
                    ex = ex + 1'b1;
                end else begin
                    ey = ey + 1'b1;
                end
            end
            prev_we_low = !bus.oSRAM_WE_N;
            if (prev_busy && !bus.oCLR_BUSY) falls++;
            prev_busy = bus.oCLR_BUSY;
            if (tail > 0) tail--;
            else if (tail < 0 && !bus.oCLR_BUSY) tail = 5;
        end
        total++;
        if (writes != (H_MAX + 1) * (V_MAX + 1))
            $display("FAIL clr_count: %0d writes required %0d", writes, (H_MAX + 1) * (V_MAX + 1));
        else passed++;
        total++;
        if (bad != 0) $display("FAIL clr_order: %0d out-of-order writes required 0", bad);
        else passed++;
        total++;
        if (bad_turn != 0) $display("FAIL clr_turn: %0d writes without turnaround required 0",
                                    bad_turn);
        else passed++;
        total++;
        if (falls != 1 || bus.oCLR_BUSY !== 1'b0)
            $display("FAIL clr_busy_fall: falls=%0d busy=%b required 1/0", falls, bus.oCLR_BUSY);
        else passed++;
        for (int x = 0; x <= H_MAX; x++)
            for (int y = 0; y <= V_MAX; y++) begin
                if (mem[pa(x, y)] !== 16'h0000) badpix++;
                exp_mem[pa(x, y)] = 16'h0000;
            end
        total++;
        if (badpix != 0) $display("FAIL clr_pixels: %0d nonzero pixels required 0", badpix);
        else passed++;
        total++;
        if (mem[pa(H_MAX + 1, 0)] !== 16'h5A5A || mem[pa(0, V_MAX + 1)] !== 16'h3C3C)
            $display("FAIL clr_bounds: %h/%h required 5a5a/3c3c", mem[pa(H_MAX + 1, 0)],
                     mem[pa(0, V_MAX + 1)]);
        else passed++;
        // Client readback of a previously written pixel after the clear
        drive_client(1'b0, 10, 20, 16'h0000);
        tail = 0;
        for (int n = 0; n < 16 && tail == 0; n++) begin
            @(negedge iCLK);
            if (bus.oCL_ACK) tail = 1;
        end
        bus.iCL_REQ = 1'b0;
        e = exp_q.pop_front();
        total++;
        if (tail != 1 || bus.oCL_RDATA !== e)
            $display("FAIL clr_readback: ack=%0d rdata=%h required 1/%h", tail, bus.oCL_RDATA, e);
        else passed++;
        @(negedge iCLK);
    endtask

    task automatic test_reset_mid_write();
        int acks = 0, wr = 0;
        bus.iCLR_START = 1'b1;
        bus.iCLR_DATA  = 16'h1111;
        drive_client(1'b1, 20, 20, 16'hBEEF);
        @(negedge iCLK);
        bus.iCLR_START = 1'b0;
        total++;
        if (bus.oSRAM_WE_N !== 1'b0 || bus.oCLR_BUSY !== 1'b1)
            $display("FAIL rst_pre: we_n=%b busy=%b required 0/1", bus.oSRAM_WE_N, bus.oCLR_BUSY);
        else passed++;
        #1 iRST_N = 1'b0;
        #1;
        total++;
        if (bus.oSRAM_WE_N !== 1'b1 || bus.oSRAM_DQ_OE !== 1'b0 || bus.oCLR_BUSY !== 1'b0)
            $display("FAIL rst_async: we_n=%b dq_oe=%b busy=%b required 1/0/0",
                     bus.oSRAM_WE_N, bus.oSRAM_DQ_OE, bus.oCLR_BUSY);
        else passed++;
        // The aborted write will never complete
        void'(exp_q.pop_back());
        exp_mem.delete(pa(20, 20));
        bus.iCL_REQ = 1'b0;
        repeat (2) @(negedge iCLK);
        iRST_N = 1'b1;
        repeat (8) begin
            @(negedge iCLK);
            if (bus.oCL_ACK) acks++;
            if (!bus.oSRAM_WE_N) wr++;
        end
        total++;
        if (acks != 0 || wr != 0)
            $display("FAIL rst_after: acks=%0d writes=%0d required 0/0", acks, wr);
        else passed++;
        total++;
        if (mem[pa(20, 20)] === 16'hBEEF)
            $display("FAIL rst_mem: sram=%h required not beef", mem[pa(20, 20)]);
        else passed++;
    endtask

    initial begin
        test_reset();
        test_vga_read();
        test_write_read();
        test_starve();
        test_write_then_vga();
        test_clear();
        test_reset_mid_write();
        total++;
        if (exp_q.size() != 0)
            $display("FAIL scoreboard_empty: %0d entries left required 0", exp_q.size());
        else passed++;
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
